// File: rtl/pixel_packer.sv
// Packs PACK pixel nibbles popped from an async FIFO read port into
// one word and hands it to the framebuffer writer on valid/ready.
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   io_rdReq_en      pop request to the FIFO (combinational)
//   io_rdReq_data    popped nibble, qualified by io_rdReq_valid
//   io_rdReq_valid   data valid, one cycle after an accepted pop
//   io_empty         FIFO empty
//   io_flush         one-cycle request to emit a partial word
//   io_out_valid     output word valid
//   io_out_ready     downstream accepts the word
//   io_out_data      packed word, first nibble in the low bits
//   io_out_mask      per-nibble valid mask
//   io_words         words accepted downstream (wraps)
//
// Build option: define PIXEL_PACKER_FLUSH_EN to enable io_flush and
// the FLUSH state. Without it io_flush is ignored.

`timescale 1ns/1ps

module pixel_packer #(
  parameter int DATA_W = 4,
  parameter int PACK   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     io_rdReq_en,
  input  logic [DATA_W-1:0]        io_rdReq_data,
  input  logic                     io_rdReq_valid,
  input  logic                     io_empty,
  input  logic                     io_flush,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [PACK*DATA_W-1:0]   io_out_data,
  output logic [PACK-1:0]          io_out_mask,
  output logic [CNT_W-1:0]         io_words
);

  localparam int CW = $clog2(PACK + 1);
  localparam int W  = PACK * DATA_W;

  typedef enum logic [1:0] {
    FILL,
`ifdef PIXEL_PACKER_FLUSH_EN
    FLUSH,
`endif
    HOLD
  } state_t;

  state_t         state;
  logic [W-1:0]   pack_q;
  logic [CW-1:0]  cnt;
  logic           inflight;

  logic [CW-1:0]  cnt_sum;
  logic           capture;
  logic           last_nib;
  logic           out_free;
  logic           xfer;
  logic           load;
  logic [PACK-1:0] load_mask;

  // Reserved slots include the nibble already popped but not yet back.
  assign cnt_sum  = cnt + CW'(inflight);

  assign io_rdReq_en = !reset && (state == FILL) && !io_empty
                       && (cnt_sum < CW'(PACK));

  // A stray valid with nothing in flight (e.g. just after reset) is dropped.
  assign capture  = io_rdReq_valid && inflight && (cnt < CW'(PACK));
  assign last_nib = capture && (cnt == CW'(PACK - 1));
  assign out_free = !io_out_valid || io_out_ready;
  assign xfer     = io_out_valid && io_out_ready;

`ifdef PIXEL_PACKER_FLUSH_EN
  logic [PACK-1:0] part_mask;

  always_comb begin
    part_mask = '0;
    for (int i = 0; i < PACK; i++)
      part_mask[i] = (CW'(i) < cnt);
  end
`else
  logic unused_flush;
  assign unused_flush = io_flush;
`endif

  always_comb begin
    load      = 1'b0;
    load_mask = '1;
    case (state)
      HOLD: load = out_free;
`ifdef PIXEL_PACKER_FLUSH_EN
      FLUSH: begin
        if (!inflight && (cnt != '0) && out_free) begin
          load      = 1'b1;
          load_mask = part_mask;
        end
      end
`endif
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= FILL;
      pack_q       <= '0;
      cnt          <= '0;
      inflight     <= 1'b0;
      io_out_valid <= 1'b0;
      io_out_data  <= '0;
      io_out_mask  <= '0;
      io_words     <= '0;
    end else begin
      // A new pop in the same cycle as a return keeps one in flight.
      if (io_rdReq_en)
        inflight <= 1'b1;
      else if (io_rdReq_valid)
        inflight <= 1'b0;

      if (capture) begin
        for (int i = 0; i < PACK; i++)
          if (cnt == CW'(i))
            pack_q[i*DATA_W +: DATA_W] <= io_rdReq_data;
        cnt <= cnt + 1'b1;
      end

      if (xfer) begin
        io_out_valid <= 1'b0;
        io_words     <= io_words + 1'b1;
      end

      // Load wins over the transfer clear so valid stays high
      // when one word leaves and the next arrives together.
      if (load) begin
        io_out_valid <= 1'b1;
        io_out_data  <= pack_q;
        io_out_mask  <= load_mask;
        pack_q       <= '0;
        cnt          <= '0;
      end

      case (state)
        FILL: begin
          if (last_nib)
            state <= HOLD;
`ifdef PIXEL_PACKER_FLUSH_EN
          else if (io_flush)
            state <= FLUSH;
`endif
        end
        HOLD: begin
          if (load)
            state <= FILL;
        end
`ifdef PIXEL_PACKER_FLUSH_EN
        FLUSH: begin
          if (!inflight && ((cnt == '0) || out_free))
            state <= FILL;
        end
`endif
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer with a behavioural FIFO read port
// and a second narrow-counter instance for the wrap check.

`timescale 1ns/1ps

module tb_pixel_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_rdReq_en;
  logic [3:0]  io_rdReq_data;
  logic        io_rdReq_valid;
  logic        io_empty;
  logic        io_flush = 1'b0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [15:0] io_out_data;
  logic [3:0]  io_out_mask;
  logic [15:0] io_words;

  logic        w_en;
  logic        w_valid;
  logic [15:0] w_data;
  logic [3:0]  w_mask;
  logic [1:0]  w_words;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pixel_packer #(.DATA_W(4), .PACK(4), .CNT_W(16)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .io_rdReq_en    (io_rdReq_en),
    .io_rdReq_data  (io_rdReq_data),
    .io_rdReq_valid (io_rdReq_valid),
    .io_empty       (io_empty),
    .io_flush       (io_flush),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_data    (io_out_data),
    .io_out_mask    (io_out_mask),
    .io_words       (io_words)
  );

  pixel_packer #(.DATA_W(4), .PACK(4), .CNT_W(2)) u_wrap (
    .clock          (clock),
    .reset          (reset),
    .io_rdReq_en    (w_en),
    .io_rdReq_data  (io_rdReq_data),
    .io_rdReq_valid (io_rdReq_valid),
    .io_empty       (io_empty),
    .io_flush       (io_flush),
    .io_out_valid   (w_valid),
    .io_out_ready   (io_out_ready),
    .io_out_data    (w_data),
    .io_out_mask    (w_mask),
    .io_words       (w_words)
  );

  logic [3:0] fifo[$];
  int pops = 0;

  always @(posedge clock) begin
    if (io_rdReq_en && fifo.size() > 0) begin
      io_rdReq_data  <= fifo.pop_front();
      io_rdReq_valid <= 1'b1;
      pops           <= pops + 1;
    end else begin
      io_rdReq_valid <= 1'b0;
    end
  end

  always @(negedge clock)
    io_empty = (fifo.size() == 0);

  logic [15:0] got_d[$];
  logic [3:0]  got_m[$];
  int          got_c[$];
  int          cyc_n = 0;

  always @(negedge clock) begin
    cyc_n++;
    if (!reset && io_out_valid && io_out_ready) begin
      got_d.push_back(io_out_data);
      got_m.push_back(io_out_mask);
      got_c.push_back(cyc_n);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    fifo.push_back(v);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    io_flush     = 1'b0;
    io_out_ready = 1'b1;
    fifo.delete();
    cyc(3);
    got_d.delete();
    got_m.delete();
    got_c.delete();
    reset = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got_d.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    if (got_d.size() < n)
      chk("timeout", got_d.size(), n);
  endtask

  initial begin
    int p0;
    int k;
    logic [3:0] nib;

    // Reset values.
    reset = 1'b1;
    cyc(3);
    chk("rst_en",    io_rdReq_en, 0);
    chk("rst_valid", io_out_valid, 0);
    chk("rst_data",  io_out_data, 0);
    chk("rst_mask",  io_out_mask, 0);
    chk("rst_words", io_words, 0);

    // Basic packing.
    do_reset();
    p0 = pops;
    for (int i = 1; i <= 8; i++) push(4'(i));
    wait_words(2, 60);
    chk("basic_w0", got_d[0], 16'h4321);
    chk("basic_w1", got_d[1], 16'h8765);
    chk("basic_m0", got_m[0], 4'hF);
    chk("basic_m1", got_m[1], 4'hF);
    chk("basic_period", got_c[1] - got_c[0], 6);
    cyc(2);
    chk("basic_words", io_words, 2);
    chk("basic_pops", pops - p0, 8);

    // Back-pressure.
    do_reset();
    io_out_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 12; i++) push(4'(i));
    cyc(10);
    chk("bp_hold_mid", io_out_data, 16'h4321);
    cyc(10);
    chk("bp_pops", pops - p0, 8);
    chk("bp_valid", io_out_valid, 1);
    chk("bp_hold", io_out_data, 16'h4321);
    chk("bp_en", io_rdReq_en, 0);
    io_out_ready = 1'b1;
    wait_words(3, 60);
    chk("bp_w0", got_d[0], 16'h4321);
    chk("bp_w1", got_d[1], 16'h8765);
    chk("bp_w2", got_d[2], 16'hCBA9);
    cyc(2);
    chk("bp_words", io_words, 3);

    // Starvation.
    do_reset();
    push(4'hA);
    push(4'hB);
    cyc(15);
    chk("starve_en", io_rdReq_en, 0);
    chk("starve_out", got_d.size(), 0);
    push(4'hC);
    push(4'hD);
    wait_words(1, 30);
    chk("starve_w0", got_d[0], 16'hDCBA);

    // Flush request.
    do_reset();
    p0 = pops;
    push(4'h5);
    push(4'h6);
    push(4'h7);
    k = 0;
    while (pops - p0 < 2 && k < 20) begin
      cyc(1);
      k++;
    end
    chk("flush_pop3", io_rdReq_en, 1);
    io_flush = 1'b1;
    cyc(1);
    io_flush = 1'b0;
`ifdef PIXEL_PACKER_FLUSH_EN
    wait_words(1, 20);
    chk("flush_w0", got_d[0], 16'h0765);
    chk("flush_m0", got_m[0], 4'b0111);
    cyc(3);
    io_flush = 1'b1;
    cyc(1);
    io_flush = 1'b0;
    cyc(10);
    chk("flush_empty", got_d.size(), 1);
    chk("flush_words", io_words, 1);
`else
    cyc(10);
    chk("noflush_out", got_d.size(), 0);
    push(4'h8);
    wait_words(1, 20);
    chk("noflush_w0", got_d[0], 16'h8765);
    chk("noflush_m0", got_m[0], 4'hF);
`endif

    // Reset mid-word with a held output word.
    do_reset();
    io_out_ready = 1'b0;
    p0 = pops;
    push(4'hA);
    push(4'hB);
    push(4'hC);
    push(4'hD);
    for (int i = 0; i < 3; i++) push(4'h9);
    k = 0;
    while (pops - p0 < 7 && k < 40) begin
      cyc(1);
      k++;
    end
    chk("mid_held", io_out_data, 16'hDCBA);
    reset = 1'b1;
    cyc(1);
    chk("mid_en",    io_rdReq_en, 0);
    chk("mid_valid", io_out_valid, 0);
    chk("mid_data",  io_out_data, 0);
    chk("mid_mask",  io_out_mask, 0);
    chk("mid_words", io_words, 0);
    cyc(1);
    reset        = 1'b0;
    io_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(4'(i));
    wait_words(1, 30);
    chk("mid_w0", got_d[0], 16'h4321);
    cyc(2);
    chk("mid_words1", io_words, 1);

    // Counter wrap on the narrow instance.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      nib = 4'(i);
      push(nib);
    end
    wait_words(5, 100);
    cyc(2);
    chk("wrap_words16", io_words, 5);
    chk("wrap_words2", w_words, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
